// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, 32 steps per op.
module mdu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] b_q;
  logic [64:0] acc;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        accept;
  logic        finish;
  logic        abort;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] msum;
  logic [64:0] mul_n;
  logic [32:0] rsh;
  logic [33:0] diff;
  logic [32:0] rem_n;
  logic [64:0] div_n;
  logic [64:0] acc_n;

  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (cnt == 5'd31) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // op[0]=0 selects the signed variants
  always_comb begin
    a_neg = ~op[0] & operand_a[31];
    b_neg = ~op[0] & operand_b[31];
    a_mag = a_neg ? (32'd0 - operand_a) : operand_a;
    b_mag = b_neg ? (32'd0 - operand_b) : operand_b;
  end

  // acc holds {upper partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum  = acc[64:32] + (acc[0] ? {1'b0, b_q} : 33'd0);
    mul_n = {1'b0, msum, acc[31:1]};
    rsh   = {acc[63:32], acc[31]};
    diff  = {1'b0, rsh} - {2'b00, b_q};
    rem_n = diff[33] ? rsh : diff[32:0];
    div_n = {rem_n, acc[30:0], ~diff[33]};
    acc_n = is_div ? div_n : mul_n;
  end

  always_comb begin
    prod   = acc_n[63:0];
    prod_s = neg_res ? (64'd0 - prod) : prod;
    quo    = acc_n[31:0];
    rem    = acc_n[63:32];
    if (is_div) begin
      res_lo = div_zero ? 32'hFFFF_FFFF
             : (neg_res ? (32'd0 - quo) : quo);
      res_hi = neg_rem ? (32'd0 - rem) : rem;
    end else begin
      res_lo = prod_s[31:0];
      res_hi = prod_s[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      b_q      <= 32'd0;
      acc      <= 65'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      if (accept) begin
        cnt      <= 5'd0;
        is_div   <= op[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= op[1] & (operand_b == 32'd0);
        b_q      <= b_mag;
        acc      <= {33'd0, a_mag};
      end else if (state == IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end else if (abort) begin
        cnt <= 5'd0;
      end else begin
        acc <= acc_n;
        cnt <= cnt + 5'd1;
        if (finish) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
- REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the iteration count at 32.
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 rst  input  1  reset, asynchronous and active-high.
- REQ-004 start  input  1  request a new operation; sampled only in IDLE.
- REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- REQ-006 operand_a  input  32  [rs]: multiplicand or dividend.
- REQ-007 operand_b  input  32  [rt]: multiplier or divisor.
- REQ-008 flush  input  1  abort any in-flight operation (exception or pipeline kill).
- REQ-009 hi_we  input  1  MTHI write strobe.
- REQ-010 lo_we  input  1  MTLO write strobe.
- REQ-011 wdata  input  32  data for MTHI/MTLO.
- REQ-012 busy  output  1  high while an operation is in flight.
- REQ-013 done  output  1  one-cycle pulse when hi/lo are updated by an operation.
- REQ-014 hi  output  32  HI register: product upper word or remainder.
- REQ-015 lo  output  32  LO register: product lower word or quotient.

Function
- REQ-016 FSM states SHALL be IDLE and RUN, with a 5-bit iteration counter.
- REQ-017 IDLE with start=1 at edge E0: latch op and operands, counter=0, go to RUN, busy=1 from E0.
- REQ-018 RUN SHALL perform one shift-add iteration (multiply) or one restoring shift-subtract iteration (divide) per edge, at edges E1..E32.
- REQ-019 At E32, hi/lo SHALL be written, the FSM SHALL return to IDLE, busy=0 and done=1 for exactly one cycle; latency from start sample to result is 32 cycles.
- REQ-020 MULTU/DIVU SHALL treat operands as unsigned; the 64-bit product SHALL be returned as {hi,lo}.
- REQ-021 Signed ops SHALL use operand magnitudes; the product and quotient SHALL be negated when operand signs differ; the remainder SHALL take the dividend's sign.
- REQ-022 Divide by zero SHALL take the full 32 cycles and return lo=0xFFFFFFFF, hi=operand_a.
- REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL return lo=0x80000000, hi=0.
- REQ-024 start while busy SHALL be ignored; operands are read only at E0, so later input changes SHALL NOT affect the result.
- REQ-025 flush in RUN SHALL return to IDLE at the next edge with busy=0, no done pulse, and hi/lo unchanged; flush in IDLE has no effect.
- REQ-026 flush and start in the same IDLE cycle: flush SHALL win and no operation starts.
- REQ-027 In IDLE without start, hi_we SHALL write hi=wdata and lo_we SHALL write lo=wdata at the next edge; both may write in the same cycle.
- REQ-028 hi_we/lo_we while busy, or coincident with an accepted start, SHALL be dropped; the issuing stage SHALL stall on busy.
- REQ-029 done and a new start in the following IDLE cycle SHALL be legal back-to-back.

Reset
- REQ-030 rst=1 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear internal operand/accumulator registers.
- REQ-031 rst asserted mid-operation SHALL abort it with no done pulse; after release the block SHALL accept start on the first edge.

Verification
- REQ-032 MULT a=0xFFFFFFFF, b=2 -> busy 32 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- REQ-035 Start MULTU 3*5, assert flush at E10 -> busy=0 at the next edge, no done, hi/lo keep their prior values; a new start is accepted next cycle.
- REQ-036 Assert hi_we=1, wdata=0x12345678 while busy -> hi unchanged; the same write in IDLE -> hi=0x12345678 next edge.
- REQ-037 Assert rst at E15 of a DIVU -> all outputs 0 asynchronously; start after release -> correct result 32 cycles later.
